// File: rtl/rob_buffer.sv
// rob_buffer: reorder buffer. Allocates tags in order, accepts out-of-order results, retires in order.
// Define ROB_BYPASS_EN to let the query port see a same-cycle result-bus write.
module rob_buffer #(
  parameter  int WORD     = 32,
  parameter  int DEPTH    = 8,
  parameter  int REG_ADDR = 5,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid,
  input  logic [REG_ADDR-1:0] alloc_rd,
  input  logic                alloc_wen,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                res_valid,
  input  logic [TAG_W-1:0]    res_tag,
  input  logic [WORD-1:0]     res_data,
  input  logic                res_exc,
  output logic                commit_valid,
  input  logic                commit_ready,
  output logic [TAG_W-1:0]    commit_tag,
  output logic [REG_ADDR-1:0] commit_rd,
  output logic                commit_wen,
  output logic [WORD-1:0]     commit_data,
  output logic                commit_exc,
  input  logic                flush,
  input  logic [TAG_W-1:0]    query_tag,
  output logic                query_ready,
  output logic [WORD-1:0]     query_data,
  output logic [TAG_W:0]      count
);

  localparam logic [TAG_W:0] PTR_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    done_q, done_d;
  logic [DEPTH-1:0]    exc_q, exc_d;
  logic [DEPTH-1:0]    wen_q;
  logic [DEPTH-1:0]    alloc_hit, res_hit, commit_hit;
  logic [REG_ADDR-1:0] rd_q   [DEPTH];
  logic [WORD-1:0]     data_q [DEPTH];

  logic [TAG_W:0]      head_q, head_d, tail_q, tail_d, count_w;
  logic [TAG_W-1:0]    head_idx, tail_idx;
  logic                full, alloc_fire, res_fire, commit_fire;
  logic                head_ready, exc_flush, flush_all;
  logic                stored_ready, bypass_hit;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  // Wrap bits make the pointer difference exact over 0..DEPTH.
  assign count_w  = tail_q - head_q;
  assign full     = (count_w == FULL_CNT);

  assign alloc_ready = reset && !full && !flush;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign res_fire    = reset && res_valid && valid_q[res_tag] && !done_q[res_tag];

  // A flush input retires nothing, so the head is hidden from the regfile that cycle.
  assign head_ready   = valid_q[head_idx] && done_q[head_idx];
  assign commit_valid = reset && !flush && head_ready;
  assign commit_fire  = commit_valid && commit_ready;
  assign exc_flush    = commit_fire && exc_q[head_idx];
  assign flush_all    = flush || exc_flush;

  assign commit_tag  = reset ? head_idx : '0;
  assign commit_rd   = reset ? rd_q[head_idx] : '0;
  assign commit_data = reset ? data_q[head_idx] : '0;
  assign commit_exc  = reset && exc_q[head_idx];
  assign commit_wen  = reset && wen_q[head_idx] && !exc_q[head_idx];
  assign count       = reset ? count_w : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign alloc_hit[gi]  = alloc_fire  && (tail_idx == TAG_W'(gi));
      assign res_hit[gi]    = res_fire    && (res_tag  == TAG_W'(gi));
      assign commit_hit[gi] = commit_fire && (head_idx == TAG_W'(gi));

      assign valid_d[gi] = !flush_all && (alloc_hit[gi] || (valid_q[gi] && !commit_hit[gi]));
      assign done_d[gi]  = !flush_all && !alloc_hit[gi] && (done_q[gi] || res_hit[gi]);
      assign exc_d[gi]   = !flush_all && !alloc_hit[gi] && (res_hit[gi] ? res_exc : exc_q[gi]);
    end
  endgenerate

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_all) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (alloc_fire)  tail_d = tail_q + PTR_ONE;
      if (commit_fire) head_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload is qualified by the status bits, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_hit[i]) begin
        rd_q[i]  <= alloc_rd;
        wen_q[i] <= alloc_wen;
      end
      if (res_hit[i]) begin
        data_q[i] <= res_data;
      end
    end
  end

  assign stored_ready = valid_q[query_tag] && done_q[query_tag];

`ifdef ROB_BYPASS_EN
  assign bypass_hit = res_valid && (res_tag == query_tag) &&
                      valid_q[query_tag] && !done_q[query_tag];
`else
  assign bypass_hit = 1'b0;
`endif

  assign query_ready = reset && (stored_ready || bypass_hit);
  assign query_data  = (reset && stored_ready) ? data_q[query_tag] :
                       (reset && bypass_hit)   ? res_data : '0;

endmodule
